regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the 32-bit processor datapath; successor to the fixed 32x32, 2-read/1-write `RegisterFile`. It adds:
- a configurable number of read ports;
- two write ports with defined priority;
- optional same-cycle write-to-read bypass;
- a per-register busy scoreboard that the pipeline uses to detect read-after-write hazards on in-flight results.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- N_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and busy-set
- BYPASS, 1, when 1 a read of a register being written this cycle returns the incoming write data

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and busy bits
- read_reg  in  N_READ*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- read_data  out  N_READ*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- read_busy  out  N_READ  busy bit of the addressed register, per port
- RegWrite0  in  1  write enable, write port 0
- write_reg0  in  ADDR_W  write address, write port 0
- write_data0  in  DATA_W  write data, write port 0
- RegWrite1  in  1  write enable, write port 1 (higher priority)
- write_reg1  in  ADDR_W  write address, write port 1
- write_data1  in  DATA_W  write data, write port 1
- busy_set  in  1  marks a register as having a pending producer
- busy_reg  in  ADDR_W  register to mark busy

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus one busy bit per register.
- Write: on a rising edge with reset=0, each enabled port stores its data at its address.
  - Both ports to the same address: port 1 data is stored; port 0 is discarded.
- Writes and busy-set to address 0 have no effect when ZERO_REG=1.
- Read (combinational) for port k, evaluated in priority order:
  - ZERO_REG=1 and address 0: read_data = 0, read_busy = 0.
  - BYPASS=1 and RegWrite1 targets the address: return write_data1.
  - else BYPASS=1 and RegWrite0 targets the address: return write_data0.
  - otherwise return the stored value.
- Busy bit of register r:
  - Set when busy_set=1 and busy_reg=r.
  - Cleared when either write port writes r.
  - Set and clear on r in the same cycle: set wins (a new producer was issued).
  - With BYPASS=1, read_busy is 0 for a register being written this cycle, unless busy_set targets that register in the same cycle.
  - With BYPASS=0, read_busy shows the registered busy bit only.
- Reset: every register and busy bit becomes 0 at the edge where reset=1. Writes and busy_set presented in that cycle are ignored.
- Reset has priority over all other inputs and may be asserted mid-operation.

## Timing
- Read latency: 0 cycles, combinational from read_reg and the registered state.
- With BYPASS=1 there is also a combinational path from the write port inputs to read_data.
- Write latency: data is visible through the stored path on the cycle after the write edge.
- Busy latency: set or clear takes effect on the cycle after the edge. Same-cycle forwarding applies only to the write-clear case under BYPASS=1.
- Outputs during and after reset:
  - read_data = 0 for every address.
  - read_busy = 0 for every port.
  - Exception: the bypass path can still forward write data combinationally during the reset cycle, although that write is not stored.
- All read ports are independent; any number of them may address the same register.

## Test plan
- Reset, then write 0xA5A5A5A5 to R5 on port 0; next cycle read R5/R0 -> 0xA5A5A5A5 / 0x00000000.
- Same-cycle collision:
  - Port 0 writes R12=0x11111111, port 1 writes R12=0xAAAAAAAA -> R12 reads 0xAAAAAAAA afterwards.
  - With BYPASS=1, R12 also reads 0xAAAAAAAA during the write cycle.
- R0 protection:
  - Write R0=0xFFFFFFFF and busy_set R0 -> R0 reads 0x00000000, read_busy=0.
  - With ZERO_REG=0, the same stimulus reads back 0xFFFFFFFF.
- Scoreboard:
  - busy_set R7 -> read_busy=1 the next cycle.
  - Write R7=0x12345678 -> read_busy=0 in the write cycle (BYPASS=1) and stays 0 afterwards.
  - busy_set and write R7 in the same cycle -> busy remains 1.
- Reset mid-operation:
  - Fill R1..R31 with their indices, busy_set R3, then assert reset for 1 cycle together with a write R9=0xDEADBEEF.
  - Required afterwards: all reads 0, all busy bits 0, R9 = 0.
- Parameter sweep: N_READ=4, DATA_W=64, BYPASS=0.
  - Write R31=0x0123456789ABCDEF.
  - During the write cycle all 4 ports reading R31 see 0; on the next cycle all 4 see 0x0123456789ABCDEF.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, two write ports and busy-set, sized by the register-file parameters.
// master drives addresses/writes; slave returns read data and busy flags combinationally.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_READ = 2
);
    logic [N_READ*ADDR_W-1:0] read_reg;
    logic [N_READ*DATA_W-1:0] read_data;
    logic [N_READ-1:0]        read_busy;
    logic                     RegWrite0;
    logic [ADDR_W-1:0]        write_reg0;
    logic [DATA_W-1:0]        write_data0;
    logic                     RegWrite1;
    logic [ADDR_W-1:0]        write_reg1;
    logic [DATA_W-1:0]        write_data1;
    logic                     busy_set;
    logic [ADDR_W-1:0]        busy_reg;

    modport master (
        output read_reg, RegWrite0, write_reg0, write_data0,
               RegWrite1, write_reg1, write_data1, busy_set, busy_reg,
        input  read_data, read_busy
    );

    modport slave (
        input  read_reg, RegWrite0, write_reg0, write_data0,
               RegWrite1, write_reg1, write_data1, busy_set, busy_reg,
        output read_data, read_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard; port 1 wins write collisions.
// Reads are 0-cycle combinational (optional write bypass); writes/busy take effect next cycle; no backpressure.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr0_en;
    logic              wr1_en;
    logic              set_en;

    assign wr0_en = bus.RegWrite0 && !(ZERO_REG != 0 && bus.write_reg0 == '0);
    assign wr1_en = bus.RegWrite1 && !(ZERO_REG != 0 && bus.write_reg1 == '0);
    assign set_en = bus.busy_set  && !(ZERO_REG != 0 && bus.busy_reg   == '0);

    // A new producer issued in the same cycle as a retiring write keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr0_en) busy_nxt[bus.write_reg0] = 1'b0;
        if (wr1_en) busy_nxt[bus.write_reg1] = 1'b0;
        if (set_en) busy_nxt[bus.busy_reg]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0_en) regs[bus.write_reg0] <= bus.write_data0;
            if (wr1_en) regs[bus.write_reg1] <= bus.write_data1;
            busy <= busy_nxt;
        end
    end

    logic [N_READ*DATA_W-1:0] rdata;
    logic [N_READ-1:0]        rbusy;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        d;
    logic                     b;
    logic                     set_hit;

    // Stored path is masked during reset; the bypass path is not, so a write in the reset cycle still forwards.
    always_comb begin
        rdata   = '0;
        rbusy   = '0;
        addr    = '0;
        d       = '0;
        b       = 1'b0;
        set_hit = 1'b0;
        for (int k = 0; k < N_READ; k++) begin
            addr    = bus.read_reg[k*ADDR_W +: ADDR_W];
            d       = reset ? '0 : regs[addr];
            b       = reset ? 1'b0 : busy[addr];
            set_hit = bus.busy_set && (bus.busy_reg == addr);
            if (BYPASS != 0) begin
                if (bus.RegWrite1 && bus.write_reg1 == addr) begin
                    d = bus.write_data1;
                    if (!set_hit) b = 1'b0;
                end else if (bus.RegWrite0 && bus.write_reg0 == addr) begin
                    d = bus.write_data0;
                    if (!set_hit) b = 1'b0;
                end
            end
            if (ZERO_REG != 0 && addr == '0) begin
                d = '0;
                b = 1'b0;
            end
            rdata[k*DATA_W +: DATA_W] = d;
            rbusy[k]                  = b;
        end
    end

    assign bus.read_data = rdata;
    assign bus.read_busy = rbusy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config, ZERO_REG=0 variant and a 64-bit/4-port/no-bypass variant.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) bus_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) bus_z ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .N_READ(4)) bus_w ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1), .BYPASS(1))
        u_a (.clk(clk), .reset(reset), .bus(bus_a));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(0), .BYPASS(1))
        u_z (.clk(clk), .reset(reset), .bus(bus_z));
    regfile_mp #(.DATA_W(64), .ADDR_W(5), .N_READ(4), .ZERO_REG(1), .BYPASS(0))
        u_w (.clk(clk), .reset(reset), .bus(bus_w));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_a.RegWrite0 = 1'b0; bus_a.write_reg0 = '0; bus_a.write_data0 = '0;
        bus_a.RegWrite1 = 1'b0; bus_a.write_reg1 = '0; bus_a.write_data1 = '0;
        bus_a.busy_set  = 1'b0; bus_a.busy_reg   = '0;
        bus_z.RegWrite0 = 1'b0; bus_z.write_reg0 = '0; bus_z.write_data0 = '0;
        bus_z.RegWrite1 = 1'b0; bus_z.write_reg1 = '0; bus_z.write_data1 = '0;
        bus_z.busy_set  = 1'b0; bus_z.busy_reg   = '0;
        bus_w.RegWrite0 = 1'b0; bus_w.write_reg0 = '0; bus_w.write_data0 = '0;
        bus_w.RegWrite1 = 1'b0; bus_w.write_reg1 = '0; bus_w.write_data1 = '0;
        bus_w.busy_set  = 1'b0; bus_w.busy_reg   = '0;
    endtask

    // Inputs change on the falling edge; checks land 1 ns later, well clear of the rising edge.
    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus_a.read_reg = '0;
        bus_z.read_reg = '0;
        bus_w.read_reg = '0;

        // Reset state
        @(negedge clk);
        bus_a.read_reg = {5'd3, 5'd5};
        #1;
        chk("reset_rd0", bus_a.read_data[31:0], 64'h0);
        chk("reset_rd1", bus_a.read_data[63:32], 64'h0);
        chk("reset_busy", bus_a.read_busy, 64'h0);

        // First write, bypass, and wide no-bypass write cycle
        cyc();
        reset = 1'b0;
        bus_a.RegWrite0 = 1'b1; bus_a.write_reg0 = 5'd5; bus_a.write_data0 = 32'hA5A5A5A5;
        bus_a.read_reg  = {5'd0, 5'd5};
        bus_w.RegWrite0 = 1'b1; bus_w.write_reg0 = 5'd31; bus_w.write_data0 = 64'h0123456789ABCDEF;
        bus_w.read_reg  = {4{5'd31}};
        #1;
        chk("byp_r5", bus_a.read_data[31:0], 64'hA5A5A5A5);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wide_wcyc_p%0d", k), bus_w.read_data[k*64 +: 64], 64'h0);

        cyc();
        #1;
        chk("rd_r5", bus_a.read_data[31:0], 64'hA5A5A5A5);
        chk("rd_r0", bus_a.read_data[63:32], 64'h0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wide_after_p%0d", k), bus_w.read_data[k*64 +: 64], 64'h0123456789ABCDEF);

        // Same-address collision: port 1 wins
        cyc();
        bus_a.RegWrite0 = 1'b1; bus_a.write_reg0 = 5'd12; bus_a.write_data0 = 32'h11111111;
        bus_a.RegWrite1 = 1'b1; bus_a.write_reg1 = 5'd12; bus_a.write_data1 = 32'hAAAAAAAA;
        bus_a.read_reg  = {5'd12, 5'd12};
        #1;
        chk("coll_byp_p0", bus_a.read_data[31:0], 64'hAAAAAAAA);
        chk("coll_byp_p1", bus_a.read_data[63:32], 64'hAAAAAAAA);
        cyc();
        #1;
        chk("coll_stored", bus_a.read_data[31:0], 64'hAAAAAAAA);

        // Register 0 protection versus ZERO_REG=0
        cyc();
        bus_a.RegWrite0 = 1'b1; bus_a.write_reg0 = 5'd0; bus_a.write_data0 = 32'hFFFFFFFF;
        bus_a.busy_set  = 1'b1; bus_a.busy_reg   = 5'd0; bus_a.read_reg = {5'd0, 5'd0};
        bus_z.RegWrite0 = 1'b1; bus_z.write_reg0 = 5'd0; bus_z.write_data0 = 32'hFFFFFFFF;
        bus_z.busy_set  = 1'b1; bus_z.busy_reg   = 5'd0; bus_z.read_reg = {5'd0, 5'd0};
        #1;
        chk("r0_wcyc_rd", bus_a.read_data[31:0], 64'h0);
        chk("r0_wcyc_busy", bus_a.read_busy, 64'h0);
        chk("z_r0_byp", bus_z.read_data[31:0], 64'hFFFFFFFF);
        cyc();
        #1;
        chk("r0_rd", bus_a.read_data, 64'h0);
        chk("r0_busy", bus_a.read_busy, 64'h0);
        chk("z_r0_rd", bus_z.read_data[31:0], 64'hFFFFFFFF);
        chk("z_r0_busy", bus_z.read_busy, 64'h3);

        // Scoreboard
        cyc();
        bus_a.busy_set = 1'b1; bus_a.busy_reg = 5'd7; bus_a.read_reg = {5'd7, 5'd7};
        #1;
        chk("set_cyc_busy", bus_a.read_busy, 64'h0);
        cyc();
        #1;
        chk("set_next_busy", bus_a.read_busy, 64'h3);
        cyc();
        bus_a.RegWrite0 = 1'b1; bus_a.write_reg0 = 5'd7; bus_a.write_data0 = 32'h12345678;
        #1;
        chk("clr_wcyc_busy", bus_a.read_busy, 64'h0);
        chk("clr_wcyc_rd", bus_a.read_data[31:0], 64'h12345678);
        cyc();
        #1;
        chk("clr_next_busy", bus_a.read_busy, 64'h0);
        chk("clr_next_rd", bus_a.read_data[63:32], 64'h12345678);
        cyc();
        bus_a.busy_set  = 1'b1; bus_a.busy_reg   = 5'd7;
        bus_a.RegWrite1 = 1'b1; bus_a.write_reg1 = 5'd7; bus_a.write_data1 = 32'h55;
        cyc();
        #1;
        chk("setclr_busy", bus_a.read_busy, 64'h3);
        chk("setclr_rd", bus_a.read_data[31:0], 64'h55);

        // Fill R1..R31 with their indices; mark R3 busy along the way
        for (int r = 1; r < 32; r++) begin
            cyc();
            bus_a.RegWrite0   = 1'b1;
            bus_a.write_reg0  = r[4:0];
            bus_a.write_data0 = 32'(r);
            if (r == 3) begin
                bus_a.busy_set = 1'b1;
                bus_a.busy_reg = 5'd3;
            end
        end
        cyc();
        bus_a.read_reg = {5'd3, 5'd9};
        #1;
        chk("fill_r9", bus_a.read_data[31:0], 64'd9);
        chk("fill_r3", bus_a.read_data[63:32], 64'd3);
        chk("fill_r3_busy", bus_a.read_busy, 64'h2);

        // Reset mid-operation with a colliding write
        cyc();
        reset = 1'b1;
        bus_a.RegWrite0 = 1'b1; bus_a.write_reg0 = 5'd9; bus_a.write_data0 = 32'hDEADBEEF;
        #1;
        chk("rst_byp_r9", bus_a.read_data[31:0], 64'hDEADBEEF);
        chk("rst_cyc_r3", bus_a.read_data[63:32], 64'h0);
        chk("rst_cyc_busy", bus_a.read_busy, 64'h0);
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_r9", bus_a.read_data[31:0], 64'h0);
        for (int r = 0; r < 32; r++) begin
            cyc();
            bus_a.read_reg = {r[4:0], r[4:0]};
            #1;
            chk($sformatf("rst_rd_r%0d", r), bus_a.read_data, 64'h0);
            chk($sformatf("rst_busy_r%0d", r), bus_a.read_busy, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
